// File: rtl/ysyx_201979054_arb_pkg.sv
// Shared types and constants for the two-requester AXI request arbiter.
package ysyx_201979054_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int REQ_INSTR = 0;
    localparam int REQ_DATA  = 1;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/ysyx_201979054_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
module ysyx_201979054_rr_arbiter2
    import ysyx_201979054_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = '0;
            if (last_grant == 1'(REQ_DATA)) gnt[REQ_INSTR] = 1'b1;
            else                            gnt[REQ_DATA]  = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_201979054_axi_arbiter.sv
// Grants the single AXI master request port to the I-side or D-side requester,
// holds it until done (or watchdog timeout), then idles one cycle before re-arbitrating.
module ysyx_201979054_axi_arbiter
    import ysyx_201979054_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [N_REQ-1:0]              i_read_req,
    input  logic [N_REQ-1:0]              i_write_req,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  i_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]  i_wdata,
    input  logic [N_REQ-1:0][7:0]         i_len,
    input  logic [N_REQ-1:0][2:0]         i_size,
    input  logic [N_REQ-1:0][7:0]         i_strb,
    output logic [N_REQ-1:0]              o_grant,
    output logic [N_REQ-1:0][DATA_W-1:0]  o_rdata,
    output logic [N_REQ-1:0]              o_handshake,
    output logic [N_REQ-1:0]              o_done,
    output logic [N_REQ-1:0]              o_err,
    output logic                          o_m_read_req,
    output logic                          o_m_write_req,
    output logic [ADDR_W-1:0]             o_m_addr,
    output logic [DATA_W-1:0]             o_m_wdata,
    output logic [7:0]                    o_m_len,
    output logic [2:0]                    o_m_size,
    output logic [1:0]                    o_m_burst,
    output logic [7:0]                    o_m_strb,
    input  logic [DATA_W-1:0]             i_m_rdata,
    input  logic                          i_m_done,
    input  logic                          i_m_handshake
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q;
    logic [1:0]       grant_q;
    logic             grant_idx_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [1:0] pending;
    logic [1:0] arb_gnt;
    logic       in_grant;
    logic       timeout;

    assign pending = i_read_req | i_write_req;

    ysyx_201979054_rr_arbiter2 u_rr (
        .req        (pending),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    assign in_grant  = (state_q == GRANT);
    assign timeout   = in_grant && (cnt_q == CNT_LAST);
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign o_grant   = grant_q;
    assign o_rdata   = {N_REQ{i_m_rdata}};
    assign o_m_burst = AXI_BURST_INCR;

    // Master-side fields follow the granted requester live; write wins over an illegal read+write.
    always_comb begin
        o_m_write_req = 1'b0;
        o_m_read_req  = 1'b0;
        o_m_addr      = '0;
        o_m_wdata     = '0;
        o_m_len       = '0;
        o_m_size      = '0;
        o_m_strb      = '0;
        o_handshake   = '0;
        o_done        = '0;
        o_err         = '0;
        if (in_grant) begin
            o_m_write_req = i_write_req[grant_idx_q];
            o_m_read_req  = i_read_req[grant_idx_q] & ~i_write_req[grant_idx_q];
            o_m_addr      = i_addr[grant_idx_q];
            o_m_wdata     = i_wdata[grant_idx_q];
            o_m_len       = i_len[grant_idx_q];
            o_m_size      = i_size[grant_idx_q];
            o_m_strb      = i_strb[grant_idx_q];
            o_handshake[grant_idx_q] = i_m_handshake;
            o_done[grant_idx_q]      = i_m_done | timeout;
            o_err[grant_idx_q]       = timeout & ~i_m_done;
        end
    end

    // NOTE: sequential state uses <= only, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_idx_q  <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        state_q     <= GRANT;
                        grant_q     <= arb_gnt;
                        grant_idx_q <= arb_gnt[1];
                        cnt_q       <= '0;
                    end
                end
                GRANT: begin
                    if (i_m_done || timeout) begin
                        state_q <= RELEASE;
                        grant_q <= '0;
                        if (i_m_done) last_grant_q <= grant_idx_q;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_201979054_axi_arbiter.sv
// Directed bench: a default-timeout instance for arbitration/routing and a TIMEOUT_CYCLES=8 instance for the watchdog.
module tb_ysyx_201979054_axi_arbiter;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [1:0]        read_req, write_req;
    logic [1:0][31:0]  addr;
    logic [1:0][63:0]  wdata;
    logic [1:0][7:0]   len, strb;
    logic [1:0][2:0]   size;
    logic [63:0]       m_rdata;
    logic              m_done, m_hs;

    logic [1:0]        g_grant, g_hs, g_done, g_err;
    logic [1:0][63:0]  g_rdata;
    logic              g_rreq, g_wreq;
    logic [31:0]       g_addr;
    logic [63:0]       g_wdata;
    logic [7:0]        g_len, g_strb;
    logic [2:0]        g_size;
    logic [1:0]        g_burst;

    logic [1:0]        t_grant, t_hs, t_done, t_err;
    logic [1:0][63:0]  t_rdata;
    logic              t_rreq, t_wreq;
    logic [31:0]       t_addr;
    logic [63:0]       t_wdata;
    logic [7:0]        t_len, t_strb;
    logic [2:0]        t_size;
    logic [1:0]        t_burst;

    ysyx_201979054_axi_arbiter dut (
        .clk(clk), .arst(arst),
        .i_read_req(read_req), .i_write_req(write_req), .i_addr(addr), .i_wdata(wdata),
        .i_len(len), .i_size(size), .i_strb(strb),
        .o_grant(g_grant), .o_rdata(g_rdata), .o_handshake(g_hs), .o_done(g_done), .o_err(g_err),
        .o_m_read_req(g_rreq), .o_m_write_req(g_wreq), .o_m_addr(g_addr), .o_m_wdata(g_wdata),
        .o_m_len(g_len), .o_m_size(g_size), .o_m_burst(g_burst), .o_m_strb(g_strb),
        .i_m_rdata(m_rdata), .i_m_done(m_done), .i_m_handshake(m_hs)
    );

    ysyx_201979054_axi_arbiter #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .arst(arst),
        .i_read_req(read_req), .i_write_req(write_req), .i_addr(addr), .i_wdata(wdata),
        .i_len(len), .i_size(size), .i_strb(strb),
        .o_grant(t_grant), .o_rdata(t_rdata), .o_handshake(t_hs), .o_done(t_done), .o_err(t_err),
        .o_m_read_req(t_rreq), .o_m_write_req(t_wreq), .o_m_addr(t_addr), .o_m_wdata(t_wdata),
        .o_m_len(t_len), .o_m_size(t_size), .o_m_burst(t_burst), .o_m_strb(t_strb),
        .i_m_rdata(m_rdata), .i_m_done(m_done), .i_m_handshake(m_hs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        cyc();
        cyc();
        arst = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget && g_grant == 2'b00; i++) cyc();
        settle();
    endtask

    // Serve one transaction on the default instance with both requests held; done in the first GRANT cycle.
    task automatic serve(input string tag, input logic [1:0] exp_g, input logic [31:0] exp_addr);
        wait_grant(4);
        check({tag, "_grant"}, 64'(g_grant), 64'(exp_g));
        check({tag, "_addr"}, 64'(g_addr), 64'(exp_addr));
        m_done = 1'b1;
        settle();
        check({tag, "_done"}, 64'(g_done), 64'(exp_g));
        cyc();
        m_done = 1'b0;
        settle();
        check({tag, "_release"}, 64'(g_grant), 64'd0);
    endtask

    initial begin
        arst = 1'b1; read_req = '0; write_req = '0; addr = '0; wdata = '0;
        len = '0; size = '0; strb = '0; m_rdata = '0; m_done = 1'b0; m_hs = 1'b0;
        do_reset();
        settle();

        // Reset state
        check("rst_grant", 64'(g_grant), 64'd0);
        check("rst_rreq",  64'(g_rreq),  64'd0);
        check("rst_wreq",  64'(g_wreq),  64'd0);
        check("rst_addr",  64'(g_addr),  64'd0);
        check("rst_burst", 64'(g_burst), 64'd1);
        check("rst_done",  64'(g_done),  64'd0);

        // Single I-side burst read
        read_req[0] = 1'b1; addr[0] = 32'h8000_0040; len[0] = 8'd7; size[0] = 3'd3;
        settle();
        check("t1_latency", 64'(g_rreq), 64'd0);
        cyc();
        check("t1_grant", 64'(g_grant), 64'd1);
        check("t1_rreq",  64'(g_rreq),  64'd1);
        check("t1_wreq",  64'(g_wreq),  64'd0);
        check("t1_addr",  64'(g_addr),  64'h8000_0040);
        check("t1_len",   64'(g_len),   64'd7);
        check("t1_size",  64'(g_size),  64'd3);
        for (int b = 0; b < 8; b++) begin
            m_hs = 1'b1;
            m_rdata = 64'h1111_0000_0000_0000 + 64'(b);
            settle();
            check("t1_hs", 64'(g_hs), 64'd1);
            check("t1_rdata0", g_rdata[0], 64'h1111_0000_0000_0000 + 64'(b));
            cyc();
        end
        m_hs = 1'b0; m_done = 1'b1;
        settle();
        check("t1_done", 64'(g_done), 64'd1);
        check("t1_err",  64'(g_err),  64'd0);
        cyc();
        m_done = 1'b0; read_req[0] = 1'b0;
        settle();
        check("t1_rel_grant", 64'(g_grant), 64'd0);
        check("t1_rel_rreq",  64'(g_rreq),  64'd0);
        cyc();
        cyc();
        check("t1_idle_grant", 64'(g_grant), 64'd0);

        // Round-robin from reset with both requesters pending
        do_reset();
        addr[0] = 32'h8000_1000; addr[1] = 32'h9000_2000; read_req = 2'b11;
        serve("rr0", 2'b01, 32'h8000_1000);
        serve("rr1", 2'b10, 32'h9000_2000);
        serve("rr2", 2'b01, 32'h8000_1000);
        serve("rr3", 2'b10, 32'h9000_2000);
        read_req = 2'b00;

        // D-side non-cacheable write with an illegal read alongside
        cyc();
        cyc();
        read_req[1] = 1'b1; write_req[1] = 1'b1; addr[1] = 32'h1000_0003; size[1] = 3'd0;
        strb[1] = 8'h08; wdata[1] = 64'h0000_0000_AB00_0000; len[1] = 8'd0;
        wait_grant(4);
        check("t3_grant", 64'(g_grant), 64'd2);
        check("t3_wreq",  64'(g_wreq),  64'd1);
        check("t3_rreq",  64'(g_rreq),  64'd0);
        check("t3_addr",  64'(g_addr),  64'h1000_0003);
        check("t3_size",  64'(g_size),  64'd0);
        check("t3_strb",  64'(g_strb),  64'h08);
        check("t3_wdata", g_wdata,      64'h0000_0000_AB00_0000);
        check("t3_burst", 64'(g_burst), 64'd1);
        m_hs = 1'b1;
        settle();
        check("t3_hs", 64'(g_hs), 64'd2);
        m_hs = 1'b0; m_done = 1'b1;
        settle();
        check("t3_done", 64'(g_done), 64'd2);
        cyc();
        m_done = 1'b0; read_req = '0; write_req = '0;

        // Watchdog: timeout fires in GRANT cycle 8
        do_reset();
        read_req[0] = 1'b1;
        cyc();
        for (int c = 1; c <= 8; c++) begin
            settle();
            if (c < 8) begin
                check("t4_early_done", 64'(t_done), 64'd0);
            end else begin
                check("t4_to_done", 64'(t_done), 64'd1);
                check("t4_to_err",  64'(t_err),  64'd1);
            end
            cyc();
        end
        check("t4_to_release", 64'(t_grant), 64'd0);
        read_req = '0;

        // Watchdog and done in the same cycle: done wins
        do_reset();
        read_req[0] = 1'b1;
        cyc();
        for (int c = 1; c < 8; c++) cyc();
        m_done = 1'b1;
        settle();
        check("t4b_done", 64'(t_done), 64'd1);
        check("t4b_err",  64'(t_err),  64'd0);
        cyc();
        m_done = 1'b0; read_req = '0;
        cyc();

        // Reset mid-transaction; last completion was requester 0, so the tie first goes to 1
        read_req = 2'b11;
        wait_grant(4);
        check("t5_pre_grant", 64'(g_grant), 64'd2);
        cyc();
        cyc();
        arst = 1'b1;
        cyc();
        settle();
        check("t5_rst_grant", 64'(g_grant), 64'd0);
        check("t5_rst_rreq",  64'(g_rreq),  64'd0);
        check("t5_rst_done",  64'(g_done),  64'd0);
        arst = 1'b0;
        cyc();
        check("t5_post_grant", 64'(g_grant), 64'd1);

        // Stray done/handshake in RELEASE and IDLE
        m_done = 1'b1;
        settle();
        check("t6_done", 64'(g_done), 64'd1);
        cyc();
        read_req = '0; m_hs = 1'b1;
        settle();
        check("t6_rel_done", 64'(g_done), 64'd0);
        check("t6_rel_hs",   64'(g_hs),   64'd0);
        cyc();
        settle();
        check("t6_idle_done",  64'(g_done),  64'd0);
        check("t6_idle_hs",    64'(g_hs),    64'd0);
        check("t6_idle_grant", 64'(g_grant), 64'd0);
        m_done = 1'b0; m_hs = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_201979054_axi_arbiter.md
Name: ysyx_201979054_axi_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single AXI4 master request interface (read/write request, addr, data, len, size, burst, strb, done, handshake).
- Requester 0 is the instruction-side cache refill port; requester 1 is the data side (cacheable block transfers and non-cacheable accesses).
- Grants one requester at a time, holds the grant until the master reports done, and routes read data, handshake and done back to the granted requester.
- A watchdog releases a grant whose transaction never completes.

Parameters:
- N_REQ, 2, number of requesters; fixed at 2 for this revision.
- TIMEOUT_CYCLES, 1024, cycles in GRANT without i_m_done before a forced release; legal range 2..65536.
- ADDR_W, 32, address width.
- DATA_W, 64, AXI data width.

Ports:
- clk  input  1  clock
- arst  input  1  reset; synchronous, active-high (sampled on rising clk only)
- i_read_req  input  [1:0]  per-requester read request, level, held until that requester's done
- i_write_req  input  [1:0]  per-requester write request, level, held until done
- i_addr  input  [1:0][31:0]  per-requester start address
- i_wdata  input  [1:0][63:0]  per-requester write beat data
- i_len  input  [1:0][7:0]  per-requester AXI burst length
- i_size  input  [1:0][2:0]  per-requester AXI size
- i_strb  input  [1:0][7:0]  per-requester write strobe
- o_grant  output  [1:0]  one-hot current grant, 0 when idle
- o_rdata  output  [1:0][63:0]  read data; i_m_rdata is fanned to both requesters
- o_handshake  output  [1:0]  i_m_handshake, gated to the granted requester only
- o_done  output  [1:0]  one-cycle completion pulse to the granted requester
- o_err  output  [1:0]  one-cycle timeout pulse, coincident with o_done
- o_m_read_req  output  1  to master
- o_m_write_req  output  1  to master
- o_m_addr  output  32  to master
- o_m_wdata  output  64  to master
- o_m_len  output  8  to master
- o_m_size  output  3  to master
- o_m_burst  output  2  to master; constant 2'b01 (INCR)
- o_m_strb  output  8  to master
- i_m_rdata  input  64  from master
- i_m_done  input  1  from master; one-cycle completion pulse
- i_m_handshake  input  1  from master; per-beat handshake pulse

Behaviour:
- FSM states: IDLE, GRANT, RELEASE. State, grant index, last_grant and watchdog counter are registered.
- Reset (arst=1 at clk edge):
  - state=IDLE, o_grant=0, last_grant=1 (requester 0 wins the first tie), counter=0.
  - All o_m_* request, data and control outputs are 0 except o_m_burst; o_done, o_err and o_handshake are 0.
  - Reset mid-transaction abandons the transaction with no done pulse. The AXI master shares the same reset.
- IDLE: a requester is pending if i_read_req[n] | i_write_req[n].
  - One pending requester: grant it.
  - Both pending: grant ~last_grant (round-robin).
  - Next state is GRANT; o_grant is registered.
  - Latency: request seen at edge t, o_m_*_req high from t+1.
- GRANT:
  - o_m_* fields are a combinational mux of the granted requester's inputs.
  - o_m_write_req = i_write_req[g].
  - o_m_read_req = i_read_req[g] & ~i_write_req[g]: write wins; simultaneous read+write from one requester is illegal and the read is masked.
  - o_handshake[g] = i_m_handshake; the other bit is 0.
  - If the granted requester drops its request before done, o_m_*_req drop with it; the grant persists until done or timeout.
  - On i_m_done: o_done[g]=1 in the same cycle (combinational), last_grant<=g, next state RELEASE.
  - Watchdog counter increments each GRANT cycle, saturating, and is cleared on entry to GRANT. At count==TIMEOUT_CYCLES-1 without i_m_done: o_done[g]=1, o_err[g]=1, next state RELEASE.
  - If i_m_done and the timeout hit in the same cycle, done wins and o_err stays 0.
- RELEASE: one cycle. o_grant=0 and o_m_*_req=0. This gives requesters one cycle to drop their request after done. Next state is IDLE.
  - Earliest back-to-back grant is the done cycle +2.
- An i_m_done or i_m_handshake arriving outside GRANT is ignored: no output pulse.
- Counter width is $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package ysyx_201979054_arb_pkg:
  - state enum (IDLE, GRANT, RELEASE);
  - REQ_INSTR=0 and REQ_DATA=1;
  - AXI_BURST_INCR=2'b01.
- Sub-module ysyx_201979054_rr_arbiter2: inputs req[1:0] and last_grant; output one-hot gnt. Combinational, instantiated once.

Test Plan:
- Reset, then only i_read_req[0]=1, addr 0x8000_0040, len 7, size 3 → o_grant=01 and o_m_read_req=1 one cycle later, addr/len/size forwarded; 8 handshakes reach o_handshake[0] only; i_m_done → o_done=01 that cycle; RELEASE; back to IDLE.
- Both requesters pending from reset → requester 0 served first, then requester 1. Requester 0 re-requests during 1's grant → 0 is granted next; the grant order alternates 0,1,0,1 over 4 transactions.
- Requester 1 non-cacheable write: addr 0x1000_0003, size 0, strb 0x08, wdata 0x0000_0000_AB00_0000 → forwarded unchanged; o_m_write_req=1, o_m_read_req=0 even though i_read_req[1]=1.
- TIMEOUT_CYCLES=8 with no i_m_done → o_done[g] and o_err[g] pulse in GRANT cycle 8. Repeat with i_m_done in that same cycle → o_err=0.
- arst asserted on the 3rd GRANT cycle → next edge: o_grant=0, o_m_*_req=0, no done. The 1st arbitration after reset favours requester 0.
- Stray i_m_done and i_m_handshake pulses in IDLE and RELEASE → no o_done or o_handshake activity.
